// File: rtl/set_bit_iterator.sv
// set_bit_iterator: accepts one vector over valid/ready, then streams its set bits
// LSB-first, one beat per accepted output transfer (one-hot mask, index, ordinal).
module set_bit_iterator #(
    parameter int unsigned WIDTH = 12
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             vec_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             onehot_o,
    output logic [$clog2(WIDTH)-1:0]     idx_o,
    output logic [$clog2(WIDTH+1)-1:0]   ord_o,
    output logic                         last_o,
    output logic                         empty_o,
    output logic                         busy_o
);

    localparam int unsigned IDXW = $clog2(WIDTH);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    typedef enum logic {
        StIdle,
        StEmit
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  rem_q;
    logic [CNTW-1:0]   ord_q;
    logic              empty_q;

    logic              emit;
    logic [WIDTH-1:0]  lowest;
    logic              rest_zero;
    logic [IDXW-1:0]   lowest_idx;
    logic              beat_last;

    assign emit      = (state_q == StEmit);
    // Two's-complement trick isolates the lowest set bit of the remaining vector.
    assign lowest    = rem_q & (~rem_q + WIDTH'(1));
    assign rest_zero = ((rem_q & ~lowest) == '0);
    assign beat_last = empty_q | rest_zero;

    // Binary-encode the one-hot lowest bit (all-zero mask encodes to 0).
    always_comb begin
        lowest_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                lowest_idx = lowest_idx | IDXW'(i);
            end
        end
    end

    // Beat outputs come straight from registered state; gated so IDLE shows all-zero.
    always_comb begin
        in_ready_o  = !emit;
        out_valid_o = emit;
        busy_o      = emit;
        onehot_o    = emit ? lowest : '0;
        idx_o       = emit ? lowest_idx : '0;
        ord_o       = (emit && !empty_q) ? ord_q : '0;
        last_o      = emit & beat_last;
        empty_o     = emit & empty_q;
    end

    // Control FSM: capture a vector in IDLE, peel one set bit per transfer in EMIT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rem_q   <= '0;
            ord_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        state_q <= StEmit;
                        rem_q   <= vec_i;
                        ord_q   <= CNTW'(1);
                        empty_q <= (vec_i == '0);
                    end
                end
                StEmit: begin
                    if (out_ready_i) begin
                        if (beat_last) begin
                            state_q <= StIdle;
                            rem_q   <= '0;
                            ord_q   <= '0;
                            empty_q <= 1'b0;
                        end else begin
                            rem_q <= rem_q & ~lowest;
                            ord_q <= ord_q + CNTW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Bench for set_bit_iterator: table-driven vectors with a beat scoreboard, plus
// hand-written sequences for mid-beat reset and input hold during EMIT.
module tb_set_bit_iterator;

    localparam int W = 12;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  vec;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  onehot;
    logic [3:0]    idx;
    logic [3:0]    ord;
    logic          last;
    logic          empty;
    logic          busy;

    set_bit_iterator #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .vec_i       (vec),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .onehot_o    (onehot),
        .idx_o       (idx),
        .ord_o       (ord),
        .last_o      (last),
        .empty_o     (empty),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] onehot;
        int           idx;
        int           ord;
        logic         last;
        logic         empty;
    } beat_t;

    typedef struct {
        logic [W-1:0] vec;
        bit           toggle;
        int           exp_beats;
        int           exp_last_idx;
    } rec_t;

    beat_t q[$];
    rec_t  tbl[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    seen_beats;
    int    seen_last_idx;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected beat list for one vector.
    task automatic push_expected(input logic [W-1:0] v);
        beat_t b;
        int    total = 0;
        int    k = 0;
        for (int i = 0; i < W; i++) total += int'(v[i]);
        if (total == 0) begin
            b.onehot = '0; b.idx = 0; b.ord = 0; b.last = 1'b1; b.empty = 1'b1;
            q.push_back(b);
        end else begin
            for (int i = 0; i < W; i++) begin
                if (v[i]) begin
                    k++;
                    b.onehot = '0;
                    b.onehot[i] = 1'b1;
                    b.idx = i; b.ord = k; b.last = (k == total); b.empty = 1'b0;
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic check_beat();
        chk("out_valid", int'(out_valid), 1);
        chk("onehot", int'(onehot), int'(q[0].onehot));
        chk("idx", int'(idx), q[0].idx);
        chk("ord", int'(ord), q[0].ord);
        chk("last", int'(last), int'(q[0].last));
        chk("empty", int'(empty), int'(q[0].empty));
        chk("in_ready_emit", int'(in_ready), 0);
        chk("busy_emit", int'(busy), 1);
    endtask

    // Called at a negedge with the DUT idle; vector is taken at the next posedge.
    task automatic accept(input logic [W-1:0] v);
        chk("in_ready_idle", int'(in_ready), 1);
        push_expected(v);
        in_valid = 1'b1;
        vec = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vec = W'($urandom);
    endtask

    // Pops/compares beats until the scoreboard empties; ends at the idle negedge.
    task automatic drain(input bit toggle);
        int cyc = 0;
        seen_beats = 0;
        seen_last_idx = -1;
        while (q.size() > 0 && cyc < 100) begin
            @(negedge clk);
            check_beat();
            out_ready = toggle ? cyc[0] : 1'b1;
            if (out_ready && out_valid) begin
                seen_beats++;
                if (last) seen_last_idx = int'(idx);
                void'(q.pop_front());
            end
            cyc++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats left, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after", int'(in_ready), 1);
        chk("out_valid_after", int'(out_valid), 0);
    endtask

    initial begin
        logic [W-1:0] b_vec;
        bit           took;

        tbl.push_back('{12'b001001000000, 1'b0, 2, 9});
        tbl.push_back('{12'b000000100000, 1'b0, 1, 5});
        tbl.push_back('{12'b000000000000, 1'b0, 1, 0});
        tbl.push_back('{12'b111100001111, 1'b1, 8, 11});
        tbl.push_back('{12'b111111111111, 1'b1, 12, 11});
        tbl.push_back('{12'b100000000000, 1'b0, 1, 11});
        tbl.push_back('{12'b000000000001, 1'b1, 1, 0});
        tbl.push_back('{12'b010101010101, 1'b0, 6, 10});

        rst_n = 1'b0; in_valid = 1'b0; vec = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_onehot", int'(onehot), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_ord", int'(ord), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_empty", int'(empty), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            accept(tbl[i].vec);
            drain(tbl[i].toggle);
            chk("beat_count", seen_beats, tbl[i].exp_beats);
            chk("last_idx", seen_last_idx, tbl[i].exp_last_idx);
        end

        // Asynchronous reset while beat 3 is presented.
        accept(12'b111100001111);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_beat();
            out_ready = 1'b1;
            void'(q.pop_front());
        end
        @(negedge clk);
        out_ready = 1'b0;
        check_beat();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_onehot", int'(onehot), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(12'b000000000110);
        drain(1'b0);
        chk("post_rst_beats", seen_beats, 2);
        chk("post_rst_last_idx", seen_last_idx, 2);

        // in_valid held high with churning vec_i during EMIT.
        b_vec = 12'b100000000001;
        accept(12'b000011000000);
        in_valid = 1'b1;
        took = 1'b0;
        for (int cyc = 0; cyc < 20 && !took; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("hold_queue_empty", q.size(), 0);
                vec = b_vec;
                push_expected(b_vec);
                took = 1'b1;
            end else begin
                check_beat();
                out_ready = 1'b1;
                void'(q.pop_front());
                vec = 12'b011111111110 & W'($urandom);
            end
        end
        chk("hold_took", int'(took), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drain(1'b0);
        chk("hold_beats", seen_beats, 2);
        chk("hold_last_idx", seen_last_idx, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
